// File: rtl/button_debouncer.sv
// Per-button synchronizer and debouncer: two-flop sync, then a stability-counting
// FSM per button producing a debounced level plus one-cycle press/release pulses.
module button_debouncer #(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] push_button,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } state_t;

    logic [NUM_BTN-1:0] pressed_raw;
    logic [NUM_BTN-1:0] s1;
    logic [NUM_BTN-1:0] s2;

    // Normalize polarity so 1 always means pressed downstream
    assign pressed_raw = ACTIVE_LOW ? ~push_button : push_button;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pressed_raw;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q   <= RELEASED;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        // A change is accepted only after s2 holds it for DEBOUNCE_CYCLES samples
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                RELEASED: begin
                    if (s2[i]) begin
                        state_d = PRESS_PEND;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                PRESS_PEND: begin
                    if (!s2[i]) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!s2[i]) begin
                        state_d = RELEASE_PEND;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                RELEASE_PEND: begin
                    if (s2[i]) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = RELEASED;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule
